// File: rtl/mx_port_csr_router_pkg.sv
// Shared constant helpers for routers that pack enabled-port register blocks
// back to back, plus the router state type.
package feat_anlz;

  typedef logic [1:0] csr_rtr_state_t;

  localparam csr_rtr_state_t ST_IDLE   = 2'd0;
  localparam csr_rtr_state_t ST_DECODE = 2'd1;
  localparam csr_rtr_state_t ST_ACCESS = 2'd2;
  localparam csr_rtr_state_t ST_RESP   = 2'd3;

  function automatic int used_ports_cnt(input int mask, input int port_cnt);
    int n;
    n = 0;
    for (int i = 0; i < port_cnt; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

  // Physical port that owns the idx-th packed block (the idx-th set mask bit).
  function automatic int enabled_to_phys(input int mask, input int port_cnt, input int idx);
    int n;
    int phys;
    n    = 0;
    phys = 0;
    for (int i = 0; i < port_cnt; i++) begin
      if (mask[i]) begin
        if (n == idx) phys = i;
        n++;
      end
    end
    return phys;
  endfunction

  function automatic int port_base(input int mask, input int port, input int reg_cnt);
    int n;
    n = 0;
    for (int i = 0; i < port; i++) begin
      if (mask[i]) n++;
    end
    return n * reg_cnt;
  endfunction

endpackage

// File: rtl/mx_port_csr_router_if.sv
// Upstream CSR bus and downstream per-port CSR bus of the router.
interface mx_port_csr_router_if #(
  parameter int PORT_CNT = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int LOCAL_W  = 4
);
  logic [ADDR_W-1:0]          csr_address;
  logic                       csr_read;
  logic                       csr_write;
  logic [DATA_W-1:0]          csr_writedata;
  logic                       csr_waitrequest;
  logic [DATA_W-1:0]          csr_readdata;
  logic                       csr_readdatavalid;
  logic [PORT_CNT-1:0]        port_read;
  logic [PORT_CNT-1:0]        port_write;
  logic [LOCAL_W-1:0]         port_address;
  logic [DATA_W-1:0]          port_writedata;
  logic [PORT_CNT*DATA_W-1:0] port_readdata;
  logic [PORT_CNT-1:0]        port_ack;

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata, port_readdata, port_ack,
    output csr_waitrequest, csr_readdata, csr_readdatavalid,
           port_read, port_write, port_address, port_writedata
  );

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata, port_readdata, port_ack,
    input  csr_waitrequest, csr_readdata, csr_readdatavalid,
           port_read, port_write, port_address, port_writedata
  );
endinterface

// File: rtl/mx_port_csr_router_addr_decode.sv
// Combinational decode of a packed flat CSR address into physical port and
// local register index.
module mx_csr_addr_decode
  import feat_anlz::*;
#(
  parameter int PORT_CNT         = 2,
  parameter int PORT_BIT_MASK    = 3,
  parameter int ONE_PORT_REG_CNT = 16,
  parameter int ADDR_W           = 8,
  localparam int LOCAL_W         = $clog2(ONE_PORT_REG_CNT),
  localparam int PORT_W          = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               valid_o,
  output logic [PORT_W-1:0]  port_o,
  output logic [LOCAL_W-1:0] local_o
);

  localparam int USED_CNT = used_ports_cnt(PORT_BIT_MASK, PORT_CNT);

  logic [ADDR_W-LOCAL_W-1:0] blk;
  logic [PORT_W-1:0]         port_map [PORT_CNT];

  for (genvar k = 0; k < PORT_CNT; k++) begin : g_map
    assign port_map[k] = PORT_W'(enabled_to_phys(PORT_BIT_MASK, PORT_CNT, k));
  end

  assign blk     = addr_i[ADDR_W-1:LOCAL_W];
  assign local_o = addr_i[LOCAL_W-1:0];

  always_comb begin
    valid_o = 1'b0;
    port_o  = '0;
    for (int k = 0; k < USED_CNT; k++) begin
      if (int'(blk) == k) begin
        valid_o = 1'b1;
        port_o  = port_map[k];
      end
    end
  end

endmodule

// File: rtl/mx_port_csr_router.sv
// Forwards upstream CSR reads/writes to the owning port's CSR slave, waits for
// its ack or a timeout, and returns the response with error accounting.
module mx_port_csr_router
  import feat_anlz::*;
#(
  parameter int PORT_CNT         = 2,
  parameter int PORT_BIT_MASK    = 3,
  parameter int ONE_PORT_REG_CNT = 16,
  parameter int ADDR_W           = 8,
  parameter int DATA_W           = 16,
  parameter int TIMEOUT          = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  mx_port_csr_router_if.slave bus,
  output logic                err_o,
  output logic [7:0]          err_cnt_o
);

  localparam int LOCAL_W = $clog2(ONE_PORT_REG_CNT);
  localparam int PORT_W  = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  csr_rtr_state_t      state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_rd_q, is_rd_d;
  logic [PORT_W-1:0]   sel_q, sel_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [PORT_CNT-1:0] prd_q, prd_d, pwr_q, pwr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic                dec_valid;
  logic [PORT_W-1:0]   dec_port;
  logic [LOCAL_W-1:0]  dec_local;
  logic [PORT_CNT-1:0] dec_onehot;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;

  mx_csr_addr_decode #(
    .PORT_CNT        (PORT_CNT),
    .PORT_BIT_MASK   (PORT_BIT_MASK),
    .ONE_PORT_REG_CNT(ONE_PORT_REG_CNT),
    .ADDR_W          (ADDR_W)
  ) u_decode (
    .addr_i (addr_q),
    .valid_o(dec_valid),
    .port_o (dec_port),
    .local_o(dec_local)
  );

  // Only the latched target port's ack and data are ever looked at.
  always_comb begin
    dec_onehot = '0;
    sel_ack    = 1'b0;
    sel_rdata  = '0;
    for (int p = 0; p < PORT_CNT; p++) begin
      if (dec_port == PORT_W'(p)) dec_onehot[p] = 1'b1;
      if (sel_q == PORT_W'(p)) begin
        sel_ack   = bus.port_ack[p];
        sel_rdata = bus.port_readdata[p*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_rd_d   = is_rd_q;
    sel_d     = sel_q;
    tmo_d     = tmo_q;
    prd_d     = prd_q;
    pwr_d     = pwr_q;
    rdata_d   = rdata_q;
    err_cnt_d = err_cnt_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.csr_read || bus.csr_write) begin
          addr_d  = bus.csr_address;
          wdata_d = bus.csr_writedata;
          is_rd_d = bus.csr_read;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_valid) begin
          sel_d   = dec_port;
          tmo_d   = '0;
          prd_d   = is_rd_q ? dec_onehot : '0;
          pwr_d   = is_rd_q ? '0 : dec_onehot;
          state_d = ST_ACCESS;
        end else begin
          rdata_d  = '0;
          rvalid_d = is_rd_q;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (sel_ack) begin
          prd_d    = '0;
          pwr_d    = '0;
          rdata_d  = sel_rdata;
          rvalid_d = is_rd_q;
          state_d  = ST_RESP;
        end else if (tmo_q == TMO_LAST) begin
          prd_d    = '0;
          pwr_d    = '0;
          rdata_d  = '0;
          rvalid_d = is_rd_q;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_rd_q   <= 1'b0;
      sel_q     <= '0;
      tmo_q     <= '0;
      prd_q     <= '0;
      pwr_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_rd_q   <= is_rd_d;
      sel_q     <= sel_d;
      tmo_q     <= tmo_d;
      prd_q     <= prd_d;
      pwr_q     <= pwr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.csr_waitrequest   = (state_q != ST_IDLE);
  assign bus.csr_readdata      = rdata_q;
  assign bus.csr_readdatavalid = rvalid_q;
  assign bus.port_read         = prd_q;
  assign bus.port_write        = pwr_q;
  assign bus.port_address      = dec_local;
  assign bus.port_writedata    = wdata_q;
  assign err_o                 = err_q;
  assign err_cnt_o             = err_cnt_q;

endmodule
